uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
- Shares one UART transmitter between NUM_REQ byte producers, e.g. a loopback echo of the receiver's output, a status reporter and a debug port.
- Grants requesters in round-robin order and latches the winner's byte.
- Pulses the transmitter start, waits for its done pulse, then enforces an inter-frame idle gap counted in baud ticks.
- A watchdog aborts a frame whose done pulse never arrives.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- GAP_TICKS, 16, tick pulses of idle after each frame before the next grant (0 = no gap).
- TIMEOUT_TICKS, 255, tick pulses allowed in WAIT_DONE before abort (1..255).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- tick  in  1  baud-tick strobe, same source as the Rx/Tx oversample tick; 1 clk wide.
- req  in  NUM_REQ  per-requester request; held high with data stable until its gnt.
- req_data  in  8*NUM_REQ  byte for requester i on bits [8i+7:8i].
- gnt  out  NUM_REQ  one-hot, 1-clk pulse: requester's byte accepted.
- tx_start  out  1  1-clk start pulse to the transmitter.
- tx_data  out  8  latched byte; stable from tx_start until the next grant.
- tx_done  in  1  1-clk frame-complete pulse from the transmitter.
- grant_id  out  3  index of the current or last granted requester.
- busy  out  1  high in every state except IDLE.
- timeout_err  out  1  1-clk pulse when the watchdog aborts a frame.

Behaviour:
- Reset (asynchronous) values:
  - Outputs: state=IDLE, gnt=0, tx_start=0, tx_data=0, grant_id=0, busy=0, timeout_err=0.
  - Internal: last_id=NUM_REQ-1, so requester 0 has first priority; gap and watchdog counters=0.
- All outputs are registered.
- States: IDLE, LOAD, WAIT_DONE, GAP.
- IDLE:
  - When any req is high at a clk edge, search from (last_id+1) mod NUM_REQ upward with wrap.
  - The first high bit wins: winner index goes to grant_id and last_id, and its byte to tx_data.
  - Next state is LOAD. With no request, stay in IDLE.
- LOAD (exactly 1 cycle):
  - gnt[grant_id]=1 and tx_start=1 in the same cycle.
  - Watchdog counter cleared. Next state is WAIT_DONE.
- WAIT_DONE:
  - On tx_done=1, go to GAP with gap counter=0, or to IDLE if GAP_TICKS==0.
  - Otherwise each tick increments the watchdog. At watchdog==TIMEOUT_TICKS-1 with tick=1, pulse timeout_err and go to GAP or IDLE as above.
  - If tx_done and the terminal tick arrive in the same cycle, tx_done wins and timeout_err stays 0.
- GAP:
  - Each tick increments the gap counter.
  - On tick with counter==GAP_TICKS-1, go to IDLE. Non-tick cycles hold the count.
- Latency: req high in IDLE at edge N gives gnt and tx_start high during cycle N+1.
- Minimum spacing between tx_start pulses: 2 + frame length + GAP_TICKS ticks (+1 clk for the IDLE decision).
- tx_done pulses outside WAIT_DONE are ignored.
- req changes outside IDLE do not affect the current frame.
- Back-to-back requests:
  - A requester keeping req high after its gnt is treated as a new request.
  - Round-robin still serves all other pending requesters first. No requester waits more than NUM_REQ-1 other frames.
- Counters are 8 bits, saturating is not needed: terminal compare resets them.
- Mid-operation reset returns to IDLE immediately. Any in-flight tx_start or gnt is dropped and last_id resets to NUM_REQ-1.
- A requester whose req falls before its gnt is simply not served. No error is raised.

Test Plan:
- Reset with req=4'b1111 held, bytes 0xA0..0xA3 -> grants in order 0,1,2,3,0. tx_data per tx_start is 0xA0,0xA1,0xA2,0xA3,0xA0. Exactly one gnt per tx_start.
- Single req[2] with data 0x5C, model Tx returning tx_done 160 ticks after start -> gnt[2] and tx_start in the same cycle, one cycle after req seen. busy stays high until 16 ticks after tx_done. Next grant no sooner than that.
- req[1] and req[3] asserted together after last grant to 1 -> requester 3 wins first, then requester 1.
- tx_done never returned, TIMEOUT_TICKS=255 -> timeout_err pulses on the 255th tick after tx_start. Arbiter then gaps and serves the next request normally.
- tx_done coincident with the 255th watchdog tick -> no timeout_err, normal completion.
- Assert rst during WAIT_DONE with req[2] pending -> all outputs 0 asynchronously. After release, req=4'b0101 grants requester 0 first.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one UART transmitter between NUM_REQ byte
// producers. It latches the winning byte, pulses tx_start, waits for tx_done
// (guarded by a tick-based watchdog), then holds off for an idle gap.
//
// state      | meaning
// -----------+---------------------------------------------------------
// S_IDLE     | waiting for any request; round-robin pick on request
// S_LOAD     | one cycle: gnt and tx_start are high together
// S_WAIT_DONE| frame in flight; watchdog counts ticks until tx_done
// S_GAP      | inter-frame idle, counts GAP_TICKS ticks
module uart_tx_arbiter #(
  parameter int NUM_REQ       = 4,
  parameter int GAP_TICKS     = 16,
  parameter int TIMEOUT_TICKS = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tick,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [8*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]   gnt,
  output logic                 tx_start,
  output logic [7:0]           tx_data,
  input  logic                 tx_done,
  output logic [2:0]           grant_id,
  output logic                 busy,
  output logic                 timeout_err
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_WAIT_DONE, S_GAP} state_t;

  // After a frame (or abort) either idle out for the gap or go straight back.
  localparam state_t POST_FRAME = (GAP_TICKS == 0) ? S_IDLE : S_GAP;
  localparam logic [7:0] GAP_LAST = 8'(GAP_TICKS - 1);
  localparam logic [7:0] WD_LAST  = 8'(TIMEOUT_TICKS - 1);
  localparam logic [NUM_REQ-1:0] ONE = {{(NUM_REQ-1){1'b0}}, 1'b1};

  state_t               r_state, w_state;
  logic [2:0]           r_last_id, w_last_id;
  logic [7:0]           r_gap_cnt, w_gap_cnt;
  logic [7:0]           r_wd_cnt, w_wd_cnt;
  logic [NUM_REQ-1:0]   r_gnt, w_gnt;
  logic                 r_tx_start, w_tx_start;
  logic [7:0]           r_tx_data, w_tx_data;
  logic [2:0]           r_grant_id, w_grant_id;
  logic                 r_busy, w_busy;
  logic                 r_timeout_err, w_timeout_err;
  logic                 w_found;
  logic [2:0]           w_win;
  logic [7:0]           w_win_data;

  // Returns {found, index}: first requester at or after last+1, with wrap.
  function automatic logic [3:0] rr_pick(input logic [NUM_REQ-1:0] req_v,
                                         input logic [2:0] last);
    logic [3:0]         res;
    logic [NUM_REQ-1:0] shifted;
    int                 idx;
    res = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx = int'(last) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      shifted = req_v >> idx;
      if (!res[3] && shifted[0]) res = {1'b1, 3'(idx)};
    end
    return res;
  endfunction

  // Round-robin winner and its byte, evaluated every cycle for the IDLE decision.
  always_comb begin
    logic [3:0]           pick;
    logic [8*NUM_REQ-1:0] data_sh;
    pick       = rr_pick(req, r_last_id);
    w_found    = pick[3];
    w_win      = pick[2:0];
    data_sh    = req_data >> (8 * int'(w_win));
    w_win_data = data_sh[7:0];
  end

  // Next-state and next-output logic; every output is registered below.
  always_comb begin
    w_state       = r_state;
    w_last_id     = r_last_id;
    w_gap_cnt     = r_gap_cnt;
    w_wd_cnt      = r_wd_cnt;
    w_gnt         = '0;
    w_tx_start    = 1'b0;
    w_tx_data     = r_tx_data;
    w_grant_id    = r_grant_id;
    w_timeout_err = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_state    = S_LOAD;
          w_grant_id = w_win;
          w_last_id  = w_win;
          w_tx_data  = w_win_data;
          w_gnt      = ONE << w_win;
          w_tx_start = 1'b1;
        end
      end
      S_LOAD: begin
        w_wd_cnt = '0;
        w_state  = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        // A done pulse on the terminal tick still counts as a clean finish.
        if (tx_done) begin
          w_gap_cnt = '0;
          w_state   = POST_FRAME;
        end else if (tick) begin
          if (r_wd_cnt == WD_LAST) begin
            w_timeout_err = 1'b1;
            w_gap_cnt     = '0;
            w_state       = POST_FRAME;
          end else begin
            w_wd_cnt = r_wd_cnt + 8'd1;
          end
        end
      end
      S_GAP: begin
        if (tick) begin
          if (r_gap_cnt == GAP_LAST) w_state = S_IDLE;
          else w_gap_cnt = r_gap_cnt + 8'd1;
        end
      end
      default: w_state = S_IDLE;
    endcase
    w_busy = (w_state != S_IDLE);
  end

  // State, counters and registered outputs; reset restarts priority at requester 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_last_id     <= 3'(NUM_REQ - 1);
      r_gap_cnt     <= '0;
      r_wd_cnt      <= '0;
      r_gnt         <= '0;
      r_tx_start    <= 1'b0;
      r_tx_data     <= '0;
      r_grant_id    <= '0;
      r_busy        <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      r_state       <= w_state;
      r_last_id     <= w_last_id;
      r_gap_cnt     <= w_gap_cnt;
      r_wd_cnt      <= w_wd_cnt;
      r_gnt         <= w_gnt;
      r_tx_start    <= w_tx_start;
      r_tx_data     <= w_tx_data;
      r_grant_id    <= w_grant_id;
      r_busy        <= w_busy;
      r_timeout_err <= w_timeout_err;
    end
  end

  assign gnt         = r_gnt;
  assign tx_start    = r_tx_start;
  assign tx_data     = r_tx_data;
  assign grant_id    = r_grant_id;
  assign busy        = r_busy;
  assign timeout_err = r_timeout_err;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: a tick generator plus a model transmitter drive
// the DUT; expected grants are queued as requests are raised and popped at
// each tx_start. Watchdog and gap lengths are counted from observed ticks.
module tb_uart_tx_arbiter;

  localparam int NREQ = 4;
  localparam int GAP  = 16;
  localparam int WDT  = 255;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            tick = 1'b0;
  logic [NREQ-1:0] req = '0;
  logic [8*NREQ-1:0] req_data = '0;
  logic [NREQ-1:0] gnt;
  logic            tx_start;
  logic [7:0]      tx_data;
  logic            tx_done = 1'b0;
  logic [2:0]      grant_id;
  logic            busy;
  logic            timeout_err;

  uart_tx_arbiter #(.NUM_REQ(NREQ), .GAP_TICKS(GAP), .TIMEOUT_TICKS(WDT)) dut (
    .clk(clk), .rst(rst), .tick(tick), .req(req), .req_data(req_data),
    .gnt(gnt), .tx_start(tx_start), .tx_data(tx_data), .tx_done(tx_done),
    .grant_id(grant_id), .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct { int id; logic [7:0] data; } exp_t;
  exp_t sb[$];

  int n_checks = 0;
  int n_errors = 0;
  int n_starts = 0;
  int n_timeouts = 0;

  // model transmitter / tick generator state
  logic [1:0] div = '0;
  bit  start_flag = 0;
  bit  tx_active = 0;
  bit  tx_hang = 0;
  int  tx_ticks = 0;
  int  frame_len = 8;

  // monitor state
  int  mon_phase = 0;
  int  mon_ticks = 0;
  bit  gap_track = 0;
  int  gap_ticks = 0;
  bit  prev_busy = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic push(input int id);
    exp_t e;
    logic [8*NREQ-1:0] sh;
    sh = req_data >> (8 * id);
    e.id = id;
    e.data = sh[7:0];
    sb.push_back(e);
  endtask

  // Tick every 4th clk; model Tx returns tx_done with its frame_len-th counted tick.
  initial forever begin
    @(negedge clk);
    tick = (div == 2'd3);
    div = div + 2'd1;
    tx_done = 1'b0;
    if (rst) begin
      start_flag = 0;
      tx_active = 0;
    end else if (start_flag) begin
      start_flag = 0;
      tx_active = 1;
      tx_ticks = 0;
    end else if (tx_active && tick) begin
      tx_ticks++;
      if (!tx_hang && tx_ticks == frame_len) begin
        tx_done = 1'b1;
        tx_active = 0;
      end else if (tx_ticks >= WDT) begin
        tx_active = 0;
      end
    end
  end

  // Output monitor: scoreboard pops at tx_start, watchdog and gap tick counts.
  always @(posedge clk) begin
    #1;
    if (rst) begin
      mon_phase = 0;
      gap_track = 0;
      prev_busy = 0;
    end else begin
      if (gap_track) begin
        if (tick) gap_ticks++;
        if (!busy) begin
          check("gap_len", 32'(gap_ticks), 32'(GAP));
          gap_track = 0;
        end
      end
      if (tx_start) begin
        n_starts++;
        if (sb.size() == 0) begin
          check("sb_underflow", 32'(sb.size()), 32'd1);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("grant_id", 32'(grant_id), 32'(e.id));
          check("tx_data", 32'(tx_data), 32'(e.data));
          check("gnt_onehot", 32'(gnt), 32'(1 << e.id));
        end
        check("start_from_idle", 32'(prev_busy), 32'd0);
        mon_phase = 1;
        mon_ticks = 0;
        start_flag = 1;
      end else begin
        if (gnt != '0) check("gnt_without_start", 32'(gnt), 32'd0);
        if (mon_phase == 1) begin
          mon_phase = 2;
        end else if (mon_phase == 2) begin
          if (tick) mon_ticks++;
          if (tx_done) begin
            check("done_tick", 32'(mon_ticks), 32'(frame_len));
            check("no_wd_on_done", 32'(timeout_err), 32'd0);
            mon_phase = 0;
            gap_track = 1;
            gap_ticks = 0;
          end else if (timeout_err) begin
            n_timeouts++;
            check("wd_tick", 32'(mon_ticks), 32'(WDT));
            mon_phase = 0;
            gap_track = 1;
            gap_ticks = 0;
          end
        end else if (timeout_err) begin
          check("stray_wd", 32'(timeout_err), 32'd0);
        end
      end
      prev_busy = busy;
    end
  end

  task automatic wait_gnt_drop(input int id);
    bit seen;
    seen = 0;
    for (int c = 0; c < 3000 && !seen; c++) begin
      @(posedge clk); #1;
      if (gnt[id]) seen = 1;
    end
    if (!seen) check($sformatf("gnt%0d_timeout", id), 32'd0, 32'd1);
    @(negedge clk);
    req[id] = 1'b0;
  endtask

  task automatic wait_idle();
    bit done;
    done = 0;
    for (int c = 0; c < 3000 && !done; c++) begin
      @(posedge clk); #1;
      if (!busy && !tx_active && !start_flag) done = 1;
    end
    if (!done) check("idle_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout at %0t", $time);
    $fatal(1, "bench time limit expired");
  end

  initial begin
    // Reset state and full round-robin rotation
    req_data = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    req = 4'b1111;
    frame_len = 8;
    repeat (3) @(negedge clk);
    #1;
    check("rst_outputs", 32'({gnt, tx_start, tx_data, grant_id, busy, timeout_err}), 32'd0);
    push(0); push(1); push(2); push(3); push(0);
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 3000 && n_starts < 5; c++) begin
      @(posedge clk); #1;
    end
    check("rotation_starts", 32'(n_starts), 32'd5);
    @(negedge clk);
    req = '0;
    wait_idle();

    // Single request: latency, then a second requester must wait out the gap
    req_data[23:16] = 8'h5C;
    frame_len = 160;
    @(negedge clk);
    req[2] = 1'b1;
    push(2);
    @(posedge clk); #1;
    check("latency_start", 32'(tx_start), 32'd1);
    check("latency_gnt", 32'(gnt), 32'h4);
    @(negedge clk);
    req[2] = 1'b0;
    req[0] = 1'b1;
    push(0);
    wait_gnt_drop(0);
    wait_idle();

    // Last grant to 1, then 1 and 3 together: 3 wins, then 1
    @(negedge clk);
    req[1] = 1'b1;
    push(1);
    wait_gnt_drop(1);
    wait_idle();
    @(negedge clk);
    req = 4'b1010;
    push(3); push(1);
    wait_gnt_drop(3);
    wait_gnt_drop(1);
    wait_idle();

    // Watchdog abort, then normal service
    tx_hang = 1;
    @(negedge clk);
    req[0] = 1'b1;
    push(0);
    wait_gnt_drop(0);
    wait_idle();
    check("timeout_count", 32'(n_timeouts), 32'd1);
    tx_hang = 0;
    frame_len = 20;
    @(negedge clk);
    req[1] = 1'b1;
    push(1);
    wait_gnt_drop(1);
    wait_idle();

    // tx_done on the terminal watchdog tick: clean completion
    frame_len = WDT;
    @(negedge clk);
    req[3] = 1'b1;
    push(3);
    wait_gnt_drop(3);
    wait_idle();
    check("coincident_no_wd", 32'(n_timeouts), 32'd1);

    // Reset mid-frame with a pending request, then restart from requester 0
    frame_len = 160;
    @(negedge clk);
    req[2] = 1'b1;
    push(2);
    wait_gnt_drop(2);
    repeat (10) @(negedge clk);
    check("busy_pre_rst", 32'(busy), 32'd1);
    req[2] = 1'b1;
    rst = 1'b1;
    #1;
    check("async_rst_outputs", 32'({gnt, tx_start, tx_data, grant_id, busy, timeout_err}), 32'd0);
    sb.delete();
    repeat (2) @(negedge clk);
    push(0); push(2);
    req = 4'b0101;
    rst = 1'b0;
    wait_gnt_drop(0);
    wait_gnt_drop(2);
    wait_idle();

    check("sb_empty", 32'(sb.size()), 32'd0);
    check("total_starts", 32'(n_starts), 32'd16);
    check("final_timeouts", 32'(n_timeouts), 32'd1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
